// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer beside EX: owns HI/LO and runs mult/multu/div/divu,
// executes mthi/mtlo and serves mfhi/mflo, stalling the front of the pipe while busy.
module mdu_ctrl #(
    parameter int unsigned FAST_MUL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [7:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] mf_data,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DLEN  = 64;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] MUL_LAST = (FAST_MUL != 0) ? CNT_W'(0) : CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [DLEN-1:0]   acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic sel_mult, sel_multu, sel_div, sel_divu;
    logic sel_mthi, sel_mtlo, sel_mfhi, sel_mflo;
    logic is_mul, is_div, div_zero;
    logic a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]   mul_sum;
    logic [DLEN-1:0] mul_step, mul_fix;
    logic [XLEN:0]   div_trial, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_new;
    logic [DLEN-1:0] div_step, div_fix;

    // Priority decode of a possibly multi-hot md_op: mult highest, mflo lowest
    assign sel_mult  = md_op[7];
    assign sel_multu = md_op[6] & ~md_op[7];
    assign sel_div   = md_op[5] & ~|md_op[7:6];
    assign sel_divu  = md_op[4] & ~|md_op[7:5];
    assign sel_mthi  = md_op[3] & ~|md_op[7:4];
    assign sel_mtlo  = md_op[2] & ~|md_op[7:3];
    assign sel_mfhi  = md_op[1] & ~|md_op[7:2];
    assign sel_mflo  = md_op[0] & ~|md_op[7:1];

    assign is_mul   = sel_mult | sel_multu;
    assign is_div   = sel_div | sel_divu;
    assign div_zero = is_div & (src_b == '0);

    assign a_neg = (sel_mult | sel_div) & src_a[XLEN-1];
    assign b_neg = (sel_mult | sel_div) & src_b[XLEN-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    // One datapath step for each iterative op, plus the sign fix-up used on the last step
    always_comb begin
        mul_sum   = {1'b0, acc_q[DLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_step  = (FAST_MUL != 0) ? (DLEN'(opd_q) * DLEN'(acc_q[XLEN-1:0]))
                                    : {mul_sum, acc_q[XLEN-1:1]};
        mul_fix   = neg_q ? -mul_step : mul_step;

        div_trial = {acc_q[DLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opd_q};
        div_ge    = ~div_diff[XLEN];
        rem_new   = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
        div_step  = {rem_new, acc_q[XLEN-2:0], div_ge};
        div_fix   = {rneg_q ? -div_step[DLEN-1:XLEN] : div_step[DLEN-1:XLEN],
                     neg_q  ? -div_step[XLEN-1:0]    : div_step[XLEN-1:0]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stallreq = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (is_mul) begin
                        opd_d    = a_mag;
                        acc_d    = {{XLEN{1'b0}}, b_mag};
                        neg_d    = a_neg ^ b_neg;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                        stallreq = 1'b1;
                    end else if (div_zero) begin
                        acc_d   = {src_a, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (is_div) begin
                        opd_d    = b_mag;
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        cnt_d    = '0;
                        state_d  = S_DIV;
                        stallreq = 1'b1;
                    end else if (sel_mthi) begin
                        hi_d = src_a;
                    end else if (sel_mtlo) begin
                        lo_d = src_a;
                    end
                end
            end
            S_MUL: begin
                stallreq = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                acc_d    = mul_step;
                if (cnt_q == MUL_LAST) begin
                    acc_d   = mul_fix;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                stallreq = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                acc_d    = div_step;
                if (cnt_q == DIV_LAST) begin
                    acc_d   = div_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                hi_d    = acc_q[DLEN-1:XLEN];
                lo_d    = acc_q[XLEN-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins everywhere: abandon the op, keep HI/LO, release the pipe
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = cnt_q;
            opd_d    = opd_q;
            acc_d    = acc_q;
            neg_d    = neg_q;
            rneg_d   = rneg_q;
            hi_d     = hi_q;
            lo_d     = lo_q;
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign mf_data = sel_mfhi ? hi_q : (sel_mflo ? lo_q : '0);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
